// File: rtl/input_debouncer_pkg.sv
// Shared FSM state encoding and glitch-counter width for input_debouncer.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/input_debouncer_sync_ff_chain.sv
// Metastability synchronizer: DEPTH flops in series, async active-low reset to 0.
module sync_ff_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces an asynchronous level: synchronize, then require DEBOUNCE_CYCLES steady samples.
// Optional build macro INPUT_DEBOUNCER_GLITCH_CNT_EN adds a saturating rejected-glitch counter.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_raw,
  output logic signal_out,
  output logic busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic             w_sync_q;
  logic             w_reject;
  logic             w_cnt_done;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_busy;

  sync_ff_chain #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(signal_raw),
    .o_q(w_sync_q)
  );

  // The entry edge already counts as the first qualifying sample, so the last
  // increment happens when the stored count is DEBOUNCE_CYCLES-1.
  assign w_cnt_done = (r_cnt == CNT_LAST);
  assign w_reject   = ((r_state == WAIT_HI) && !w_sync_q) ||
                      ((r_state == WAIT_LO) &&  w_sync_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          if (w_sync_q) begin
            if (SINGLE) begin
              r_state <= STABLE_HI;
              r_out   <= 1'b1;
            end else begin
              r_state <= WAIT_HI;
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (!w_sync_q) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_cnt_done) begin
            r_state <= STABLE_HI;
            r_out   <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!w_sync_q) begin
            if (SINGLE) begin
              r_state <= STABLE_LO;
              r_out   <= 1'b0;
            end else begin
              r_state <= WAIT_LO;
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (w_sync_q) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_cnt_done) begin
            r_state <= STABLE_LO;
            r_out   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign signal_out = r_out;
  assign busy       = r_busy;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_glitch_cnt <= '0;
    end else if (w_reject && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
    end
  end

  assign glitch_count = r_glitch_cnt;
`else
  logic w_unused_reject;
  assign w_unused_reject = w_reject;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: run-length model checked every cycle plus hand-computed edge numbers.
module tb_input_debouncer;

  localparam int SYNC_A = 2;
  localparam int DEB_A  = 16;
  localparam int SYNC_B = 2;
  localparam int DEB_B  = 1;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic out_a, busy_a, out_b, busy_b;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] gc_a, gc_b;
`endif

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(SYNC_A), .DEBOUNCE_CYCLES(DEB_A)) u_dut_a (
    .clk(clk), .rst(rst), .signal_raw(raw_a), .signal_out(out_a), .busy(busy_a)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_count(gc_a)
`endif
  );

  input_debouncer #(.SYNC_STAGES(SYNC_B), .DEBOUNCE_CYCLES(DEB_B)) u_dut_b (
    .clk(clk), .rst(rst), .signal_raw(raw_b), .signal_out(out_b), .busy(busy_b)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_count(gc_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Edge numbering: edge 1 is the first rising clk edge after rst is released.
  int   edge_num   = 0;
  logic edge_valid = 1'b0;
  logic raw_a_s    = 1'b0;
  logic raw_b_s    = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_num <= 0;
    else      edge_num <= edge_num + 1;
  end

  always @(posedge clk) begin
    edge_valid <= rst;
    raw_a_s    <= raw_a;
    raw_b_s    <= raw_b;
  end

  // Model: the FSM sees the raw level delayed by the synchronizer depth; the
  // output flips once DEB consecutive samples differ from it, and any shorter
  // run that ends back at the output level counts as a rejected glitch.
  bit m_hist  [2][4];
  bit m_out   [2];
  int m_run   [2];
  int m_glitch[2];

  function automatic void m_reset(input int ch);
    for (int i = 0; i < 4; i++) m_hist[ch][i] = 1'b0;
    m_out[ch]    = 1'b0;
    m_run[ch]    = 0;
    m_glitch[ch] = 0;
  endfunction

  function automatic void m_step(input int ch, input bit raw, input int depth, input int deb);
    bit seen;
    seen = m_hist[ch][depth-1];
    for (int i = depth - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
    m_hist[ch][0] = raw;
    if (seen != m_out[ch]) begin
      m_run[ch]++;
      if (m_run[ch] >= deb) begin
        m_out[ch] = seen;
        m_run[ch] = 0;
      end
    end else begin
      if (m_run[ch] > 0 && m_glitch[ch] < 255) m_glitch[ch]++;
      m_run[ch] = 0;
    end
  endfunction

  // Observed output history of the DUTs, cleared by reset.
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   a_rises = 0, a_falls = 0, a_last_rise = -1, a_last_fall = -1;
  int   b_changes = 0, b_first_rise = -1, b_first_fall = -1;
  int   b_busy_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_reset(0);
        m_reset(1);
        prev_a = 1'b0; prev_b = 1'b0;
        a_rises = 0; a_falls = 0; a_last_rise = -1; a_last_fall = -1;
        b_changes = 0; b_first_rise = -1; b_first_fall = -1;
      end else if (edge_valid) begin
        m_step(0, raw_a_s, SYNC_A, DEB_A);
        m_step(1, raw_b_s, SYNC_B, DEB_B);
        if (out_a !== prev_a) begin
          if (out_a) begin a_rises++; a_last_rise = edge_num; end
          else       begin a_falls++; a_last_fall = edge_num; end
        end
        if (out_b !== prev_b) begin
          b_changes++;
          if (out_b && b_first_rise < 0) b_first_rise = edge_num;
          if (!out_b && b_first_fall < 0) b_first_fall = edge_num;
        end
        prev_a = out_a;
        prev_b = out_b;
      end
      if (busy_b === 1'b1) b_busy_seen = 1;
      check("model_out_a",  int'(out_a),  int'(m_out[0]));
      check("model_busy_a", int'(busy_a), int'(m_run[0] > 0));
      check("model_out_b",  int'(out_b),  int'(m_out[1]));
      check("model_busy_b", int'(busy_b), int'(m_run[1] > 0));
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
      check("model_glitch_a", int'(gc_a), m_glitch[0]);
      check("model_glitch_b", int'(gc_b), m_glitch[1]);
`endif
    end
  end

  task automatic to_edge(input int n);
    int guard = 0;
    while (edge_num < n && guard < 5000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 5000) check("to_edge_timeout", edge_num, n);
  endtask

  task automatic do_reset(input bit raw_level);
    @(posedge clk);
    #3;
    rst   = 1'b0;
    raw_a = raw_level;
    raw_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge=%0d", edge_num);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the raw input already high: outputs held low, then a normal rise.
    rst   = 1'b0;
    raw_a = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_out_a",  int'(out_a),  0);
    check("reset_busy_a", int'(busy_a), 0);
    rst = 1'b1;
    to_edge(40);
    check("held_high_rise_count", a_rises, 1);
    check("held_high_rise_edge",  a_last_rise, 1 + SYNC_A + DEB_A - 1);

    // Clean edges on A, and a 4-cycle toggle on the DEB=1 instance B.
    do_reset(1'b0);
    to_edge(5);
    fork
      begin
        to_edge(9);
        raw_a = 1'b1;
        to_edge(59);
        raw_a = 1'b0;
        to_edge(90);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          raw_b = ~raw_b;
          to_edge(9 + 4 * k);
        end
      end
    join
    check("clean_rise_edge",  a_last_rise, 27);
    check("clean_fall_edge",  a_last_fall, 77);
    check("clean_rise_count", a_rises, 1);
    check("b_first_rise",     b_first_rise, 8);
    check("b_first_fall",     b_first_fall, 12);
    check("b_change_count",   b_changes, 10);
    check("b_busy_never",     b_busy_seen, 0);

    // Bounce: 5 high, 3 low, then steady high.
    do_reset(1'b0);
    to_edge(5);
    raw_a = 1'b1;
    to_edge(10);
    raw_a = 1'b0;
    to_edge(13);
    raw_a = 1'b1;
    to_edge(60);
    check("bounce_rise_count", a_rises, 1);
    check("bounce_rise_edge",  a_last_rise, 31);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("bounce_glitch", int'(gc_a), 1);
`endif

    // Near miss: 15 synchronized high samples, then low.
    do_reset(1'b0);
    to_edge(5);
    raw_a = 1'b1;
    to_edge(20);
    raw_a = 1'b0;
    to_edge(22);
    check("near_miss_busy_at_15", int'(busy_a), 1);
    to_edge(23);
    check("near_miss_busy_drop",  int'(busy_a), 0);
    to_edge(60);
    check("near_miss_rise_count", a_rises, 0);
    check("near_miss_out",        int'(out_a), 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("near_miss_glitch", int'(gc_a), 1);
`endif

    // Reset mid-qualification, then raw held high through and after reset.
    do_reset(1'b0);
    to_edge(5);
    raw_a = 1'b1;
    to_edge(8);
    raw_a = 1'b0;
    to_edge(11);
    raw_a = 1'b1;
    to_edge(18);
    check("midq_busy_before", int'(busy_a), 1);
    check("midq_no_rise_yet", a_rises, 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("midq_glitch_before", int'(gc_a), 1);
`endif
    #1;
    rst = 1'b0;
    #1;
    check("midq_out_after_rst",  int'(out_a),  0);
    check("midq_busy_after_rst", int'(busy_a), 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    check("midq_glitch_after_rst", int'(gc_a), 0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    to_edge(40);
    check("midq_resume_rise_count", a_rises, 1);
    check("midq_resume_rise_edge",  a_last_rise, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
